// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// bcd_to_bin_seq : packed BCD to unsigned binary, one digit per clock, MSD first
// Revision 1.0
// ============================================================================
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_t              state;
    state_t              state_next;
    logic [BIN_W-1:0]    acc;
    logic [BIN_W-1:0]    acc_next;
    logic [4*DIGITS-1:0] shreg;
    logic [CNT_W-1:0]    cnt;
    logic                bad_digit;
    logic                last_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // acc*10 built from shifts; the MS nibble of the shift register is the next digit
    assign acc_next   = (acc << 3) + (acc << 1) + BIN_W'(shreg[4*DIGITS-1 -: 4]);
    assign last_digit = (cnt == LAST_CNT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = bad_digit ? DONE : CONV;
            CONV:    if (last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            shreg   <= '0;
        end else begin
            // Flags follow the next state so they are registered, not decoded from start
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= bcd_in;
                        acc   <= '0;
                        cnt   <= '0;
                        err   <= bad_digit;
                        if (bad_digit) begin
                            bin_out <= '0;
                        end
                    end
                end
                CONV: begin
                    acc   <= acc_next;
                    shreg <= shreg << 4;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_digit) begin
                        bin_out <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// tb_bcd_to_bin_seq : scoreboard bench for bcd_to_bin_seq
// Revision 1.0
// ============================================================================
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic                clk    = 1'b0;
    logic                rst_n  = 1'b0;
    logic                start  = 1'b0;
    logic [4*DIGITS-1:0] bcd_in = '0;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    bin_out;
    logic                err;

    int total = 0;
    int bad   = 0;

    // {err, bin} expected per accepted conversion
    logic [BIN_W:0] exp_q[$];
    logic [BIN_W:0] mon_exp;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .bin_out(bin_out),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [BIN_W:0] model(input logic [4*DIGITS-1:0] bcd);
        int  v;
        bit  e;
        v = 0;
        e = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] > 4'd9) e = 1'b1;
            v = v * 10 + int'(bcd[4*i +: 4]);
        end
        if (e) return {1'b1, {BIN_W{1'b0}}};
        return {1'b0, BIN_W'(v)};
    endfunction

    always @(posedge clk) begin
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("bin_out", {22'b0, bin_out}, {22'b0, mon_exp[BIN_W-1:0]});
                check("err", {31'b0, err}, {31'b0, mon_exp[BIN_W]});
            end
        end
    end

    task automatic run(input logic [4*DIGITS-1:0] bcd, input logic [4*DIGITS-1:0] mid_bcd,
                       input bit hold);
        logic [BIN_W:0] m;
        int             lat;
        m = model(bcd);
        exp_q.push_back(m);
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        #1;
        check("busy_k", {31'b0, busy}, 32'd1);
        if (!hold) start = 1'b0;
        bcd_in = mid_bcd;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        check("latency", lat, m[BIN_W] ? 0 : DIGITS);
        @(posedge clk);
        #1;
        check("done_pulse", {31'b0, done}, 32'd0);
        check("busy_idle", {31'b0, busy}, 32'd0);
        check("bin_hold", {22'b0, bin_out}, {22'b0, m[BIN_W-1:0]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start  = i[0];
            bcd_in = 12'($urandom);
            @(posedge clk);
            #1;
            check("rst_outs", {19'b0, busy, done, err, bin_out}, 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run(12'h999, 12'h123, 1'b0);
        run(12'h000, 12'h456, 1'b0);
        run(12'h105, 12'h000, 1'b0);
        run(12'h010, 12'h999, 1'b0);
        run(12'h900, 12'h111, 1'b0);
        run(12'h1A3, 12'h222, 1'b0);
        run(12'h042, 12'h333, 1'b0);
        // start held high; the operand changed mid-conversion only feeds the next one
        run(12'h321, 12'h777, 1'b1);
        run(12'h777, 12'hFFF, 1'b0);

        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h555;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", {19'b0, busy, done, err, bin_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", {19'b0, busy, done, err, bin_out}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("idle_after_rst", {31'b0, busy}, 32'd0);
        run(12'h268, 12'h000, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential converter from packed multi-digit BCD to unsigned binary; the reverse direction of the BCD adder path.
- Consumes BCD results (e.g. adder sums) and produces binary values for downstream arithmetic and compare logic.
- Processes one digit per clock, most-significant digit first, using acc = acc*10 + digit.
- Uses a start/busy/done handshake and flags any non-BCD nibble.

Parameters:
- DIGITS, 3, number of BCD digits in bcd_in (≥1).
- BIN_W, 10, binary result width. Must satisfy 2^BIN_W > 10^DIGITS − 1. With the default, 999 fits in 10 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD operand; digit 0 is bits [3:0], and the MS digit is the top nibble.
- busy  output  1  high while not in IDLE.
- done  output  1  single-cycle pulse when bin_out/err are valid.
- bin_out  output  BIN_W  binary result; held until the next accepted start.
- err  output  1  high when the last accepted operand contained a nibble > 9; held with bin_out.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, err=0, bin_out=0; internal acc, digit counter and shift register cleared.
- States: IDLE, CONV, DONE.
- IDLE, start=1 at edge k:
  - Capture bcd_in into the shift register; acc=0; count=0.
  - If any nibble > 9: go to DONE; bin_out=0; err=1.
  - Otherwise: go to CONV; err=0.
  - busy=1 from edge k.
- IDLE, start=0: remain in IDLE.
- CONV, each edge:
  - acc_next = (acc<<3) + (acc<<1) + MS nibble of the shift register.
  - Shift the register left by 4; count++.
  - At edge k+DIGITS (count reaches DIGITS): bin_out = acc_next; go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE; busy drops.
- Latency:
  - Valid operand: done high in the cycle after edge k+DIGITS (the 4th cycle after the start edge for DIGITS=3).
  - Invalid operand: done high in the cycle after edge k.
- Arithmetic: acc is BIN_W bits wide and wraps modulo 2^BIN_W. Wrap cannot occur when the BIN_W constraint holds.
- start while busy (CONV or DONE): ignored and not queued. bcd_in changes after capture do not affect the result.
- Back-to-back operation: start high in the cycle immediately after the DONE cycle (state=IDLE) is accepted. Minimum throughput is one conversion per DIGITS+2 cycles.
- bin_out/err persistence: values are stable from the DONE cycle until the next accepted start. They are then stable or rewritten only at conversion end: bin_out changes at edge k+DIGITS (or edge k for invalid); err updates at edge k.
- Reset mid-operation: any state goes to IDLE immediately. No done pulse; outputs cleared to reset values.
- done and busy are registered outputs (no combinational path from start).

Test Plan:
- Reset: hold rst_n=0, toggle start and bcd_in → busy=0, done=0, err=0, bin_out=0 throughout.
- bcd_in=12'h999, start pulse at edge k → busy high from k; done=1 only in the cycle after edge k+3; bin_out=10'd999; err=0.
- Sequence 12'h000 → 0, 12'h105 → 105, 12'h010 → 10, 12'h900 → 900. Each start is issued the cycle after the previous done; every conversion is accepted with no lost start.
- bcd_in=12'h1A3 → done in the cycle after the start edge; err=1; bin_out=0. A following valid 12'h042 → err=0, bin_out=42.
- Hold start=1 continuously and change bcd_in during CONV → result matches only the captured operand. The next conversion starts only from the IDLE cycle after done.
- Assert rst_n=0 asynchronously mid-CONV (between clock edges) → busy, done, err and bin_out go to 0 immediately. No done follows; a new start after release converts correctly.
